mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/rv_mem_pkg.sv | 21 ++
 rtl/mem_arb_picker.sv | 32 +++
 rtl/mem_arbiter.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/rv_mem_pkg.sv
// Shared types and constants for the memory arbiter slice: FSM state
// encoding, requester identity and the memory word size in bytes.
package rv_mem_pkg;

  // Arbiter FSM: idle, or serving the instruction or data side
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } state_t;

  // Identity of a requester, also used as the round-robin history value
  typedef enum logic {
    GRANT_I = 1'b0,
    GRANT_D = 1'b1
  } grant_t;

  // Memory is word addressed in bytes; each beat moves one 32-bit word
  localparam int WORD_BYTES = 4;

endpackage

// File: rtl/mem_arb_picker.sv
// Combinational winner selection between the I-cache and D-side requesters.
// Build option MEM_ARB_RR_EN: when defined, a tie goes to the requester that
// did not win last time (last_grant input present); when undefined, the data
// side always wins a tie and there is no history input at all.
module mem_arb_picker
  import rv_mem_pkg::*;
(
  input  logic   i_elig,
  input  logic   d_elig,
`ifdef MEM_ARB_RR_EN
  input  grant_t last_grant,
`endif
  output logic   any_req,
  output grant_t winner
);

  // Pick a winner from the eligible requests; a lone request always wins
  always_comb begin
    any_req = i_elig | d_elig;
    winner  = GRANT_I;
    if (i_elig && d_elig) begin
`ifdef MEM_ARB_RR_EN
      winner = (last_grant == GRANT_I) ? GRANT_D : GRANT_I;
`else
      winner = GRANT_D;
`endif
    end else if (d_elig) begin
      winner = GRANT_D;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: I-cache line refills (BEATS-word read bursts) and
// D-side single-word writes or line reads share one memory port.
// Build option MEM_ARB_RR_EN: round-robin arbitration with a last_grant
// register; undefined gives fixed priority with D over I.
module mem_arbiter
  import rv_mem_pkg::*;
#(
  parameter int BEATS = 4,
  parameter int AW    = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_rvalid,
  output logic [31:0]   i_rdata,
  output logic          i_done,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [31:0]   d_wdata,
  output logic          d_rvalid,
  output logic [31:0]   d_rdata,
  output logic          d_done,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic          mem_ready,
  input  logic [31:0]   mem_rdata,
  output logic          waiting
);

  localparam int CW  = $clog2(BEATS);
  localparam int WB  = $clog2(WORD_BYTES);
  localparam int OFF = CW + WB;
  localparam logic [AW-1:0] LINE_MASK = {{(AW-OFF){1'b1}}, {OFF{1'b0}}};

  state_t        state;
  logic [CW-1:0] beat;
  logic [AW-1:0] base;
  logic          op_we;
  logic [31:0]   wdata_q;

  logic          i_elig;
  logic          d_elig;
  logic          any_req;
  grant_t        winner;
  logic          serving;
  logic          last_beat;
  logic [AW-1:0] sel_addr;
  logic          sel_we;
  logic [31:0]   sel_wdata;

`ifdef MEM_ARB_RR_EN
  grant_t        last_grant;
`endif

  // A requester whose burst is completing this cycle must not be re-granted
  assign i_elig = i_req & ~i_done;
  assign d_elig = d_req & ~d_done;

  mem_arb_picker u_picker (
    .i_elig     (i_elig),
    .d_elig     (d_elig),
`ifdef MEM_ARB_RR_EN
    .last_grant (last_grant),
`endif
    .any_req    (any_req),
    .winner     (winner)
  );

  assign serving   = (state != IDLE);
  assign last_beat = op_we | (beat == CW'(BEATS - 1));

  // Operands of the winning request; the I side only ever reads
  always_comb begin
    sel_addr  = i_addr;
    sel_we    = 1'b0;
    sel_wdata = '0;
    if (winner == GRANT_D) begin
      sel_addr  = d_addr;
      sel_we    = d_we;
      sel_wdata = d_wdata;
    end
  end

  // Memory port: beat words stay inside the line, writes use the raw address
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (serving) begin
      mem_req   = 1'b1;
      mem_we    = op_we;
      mem_wdata = wdata_q;
      mem_addr  = op_we ? base : {base[AW-1:OFF], beat, {WB{1'b0}}};
    end
  end

  // Stall whenever a transfer is in flight or about to be granted
  assign waiting = ~rst & (serving | any_req);

  // Arbiter FSM with registered beat, data and completion outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      beat     <= '0;
      base     <= '0;
      op_we    <= 1'b0;
      wdata_q  <= '0;
      i_rvalid <= 1'b0;
      i_rdata  <= '0;
      i_done   <= 1'b0;
      d_rvalid <= 1'b0;
      d_rdata  <= '0;
      d_done   <= 1'b0;
`ifdef MEM_ARB_RR_EN
      last_grant <= GRANT_I;
`endif
    end else begin
      i_rvalid <= 1'b0;
      i_done   <= 1'b0;
      d_rvalid <= 1'b0;
      d_done   <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            state   <= (winner == GRANT_D) ? SERVE_D : SERVE_I;
            base    <= sel_we ? sel_addr : (sel_addr & LINE_MASK);
            op_we   <= sel_we;
            wdata_q <= sel_wdata;
            beat    <= '0;
`ifdef MEM_ARB_RR_EN
            last_grant <= winner;
`endif
          end
        end
        SERVE_I, SERVE_D: begin
          if (mem_ready) begin
            beat <= beat + 1'b1;
            if (state == SERVE_I) begin
              if (!op_we) begin
                i_rvalid <= 1'b1;
                i_rdata  <= mem_rdata;
              end
              i_done <= last_beat;
            end else begin
              if (!op_we) begin
                d_rvalid <= 1'b1;
                d_rdata  <= mem_rdata;
              end
              d_done <= last_beat;
            end
            if (last_beat) begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
